// File: rtl/bcd_to_state_encoder.sv
// Debounces a held BCD digit and commits it as a small state code with a valid/ready handshake.
// Digits above MAX_CODE raise a one-cycle error pulse instead of committing.
module bcd_to_state_encoder #(
   parameter int STABLE_CYCLES = 4,
   parameter int MAX_CODE      = 4
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic [3:0] i_bcd,
   input  logic       i_bcd_valid,
   input  logic       i_ready,
   output logic [2:0] o_code,
   output logic       o_valid,
   output logic       o_err,
   output logic       o_busy
);

   typedef enum logic [2:0] {IDLE, FILTER, CHECK, OUTPUT, WAIT_RELEASE} state_t;

   localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);
   localparam logic [4:0] MAX_C  = 5'(MAX_CODE);

   state_t     state, state_nxt;
   logic [3:0] cand, cand_nxt;
   logic [3:0] count, count_nxt;
   logic [2:0] code_nxt;
   logic       valid_nxt, err_nxt;

   always_comb begin
      state_nxt = state;
      cand_nxt  = cand;
      count_nxt = count;
      code_nxt  = o_code;
      valid_nxt = o_valid;
      err_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (i_bcd_valid) begin
               cand_nxt  = i_bcd;
               count_nxt = 4'd1;
               state_nxt = FILTER;
            end
         end
         FILTER: begin
            if (!i_bcd_valid) begin
               count_nxt = 4'd0;
               state_nxt = IDLE;
            end else if (i_bcd != cand) begin
               cand_nxt  = i_bcd;
               count_nxt = 4'd1;
            end else begin
               // STABLE never exceeds 15, so leaving here keeps count from wrapping
               count_nxt = count + 4'd1;
               if (count_nxt >= STABLE) state_nxt = CHECK;
            end
         end
         CHECK: begin
            count_nxt = 4'd0;
            if ({1'b0, cand} <= MAX_C) begin
               code_nxt  = cand[2:0];
               valid_nxt = 1'b1;
               state_nxt = OUTPUT;
            end else begin
               err_nxt   = 1'b1;
               state_nxt = WAIT_RELEASE;
            end
         end
         OUTPUT: begin
            if (o_valid && i_ready) begin
               valid_nxt = 1'b0;
               state_nxt = WAIT_RELEASE;
            end
         end
         WAIT_RELEASE: begin
            if (!i_bcd_valid) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state   <= IDLE;
         cand    <= 4'd0;
         count   <= 4'd0;
         o_code  <= 3'd0;
         o_valid <= 1'b0;
         o_err   <= 1'b0;
         o_busy  <= 1'b0;
      end else begin
         state   <= state_nxt;
         cand    <= cand_nxt;
         count   <= count_nxt;
         o_code  <= code_nxt;
         o_valid <= valid_nxt;
         o_err   <= err_nxt;
         o_busy  <= (state_nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_bcd_to_state_encoder.sv
// Directed bench for bcd_to_state_encoder with an event-level reference model checked every cycle.
module tb_bcd_to_state_encoder;

   localparam int S = 4;
   localparam int M = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] bcd;
   logic       bcd_valid;
   logic       ready;
   logic [2:0] code;
   logic       valid, err, busy;

   int total = 0;
   int bad   = 0;
   bit checking = 1'b0;

   bcd_to_state_encoder #(.STABLE_CYCLES(S), .MAX_CODE(M)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_bcd(bcd), .i_bcd_valid(bcd_valid),
      .i_ready(ready), .o_code(code), .o_valid(valid), .o_err(err), .o_busy(busy)
   );

   always #5 clk = ~clk;

   // Reference: a run of identical valid samples of length S schedules a verdict one edge later;
   // a committed code waits for ready, and any verdict blocks further commits until release.
   int m_cand = 0, m_run = 0, m_code = 0;
   bit m_due = 0, m_pend = 0, m_blk = 0, m_err = 0, m_busy = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_cand = 0; m_run = 0; m_code = 0;
         m_due = 0; m_pend = 0; m_blk = 0; m_err = 0;
      end else begin
         m_err = 0;
         if (m_due) begin
            m_due = 0;
            if (m_cand <= M) begin m_pend = 1; m_code = m_cand % 8; end
            else begin m_err = 1; m_blk = 1; end
         end else if (m_pend) begin
            if (ready) begin m_pend = 0; m_blk = 1; end
         end else if (m_blk) begin
            if (!bcd_valid) m_blk = 0;
         end else if (bcd_valid) begin
            if (m_run > 0 && int'(bcd) == m_cand) m_run++;
            else begin m_cand = int'(bcd); m_run = 1; end
            if (m_run == S) begin m_due = 1; m_run = 0; end
         end else begin
            m_run = 0;
         end
      end
      m_busy = (m_run > 0) || m_due || m_pend || m_blk;
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (checking) begin
         chk("cyc_valid", int'(valid), int'(m_pend));
         chk("cyc_err",   int'(err),   int'(m_err));
         chk("cyc_busy",  int'(busy),  int'(m_busy));
         chk("cyc_code",  int'(code),  m_code);
      end
   end

   // Hand-computed value checked against both the DUT and the model.
   task automatic lit(input string name, input int act, input int mdl, input int exp);
      chk({name, "_dut"}, act, exp);
      chk({name, "_model"}, mdl, exp);
   endtask

   task automatic step(input bit r, input bit v, input int b, input bit rdy);
      rst_n     = r;
      bcd_valid = v;
      bcd       = 4'(b);
      ready     = rdy;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic hold(input int n, input int b, input bit rdy);
      for (int i = 0; i < n; i++) step(1, 1, b, rdy);
   endtask

   initial begin
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      checking = 1'b1;
      lit("rst_valid", int'(valid), int'(m_pend), 0);
      lit("rst_code",  int'(code),  m_code, 0);
      lit("rst_busy",  int'(busy),  int'(m_busy), 0);
      lit("rst_err",   int'(err),   int'(m_err), 0);

      // digit 3 held, ready high: valid exactly one cycle after E4, no recommit
      hold(4, 3, 1);
      lit("d3_latency", int'(valid), int'(m_pend), 0);
      hold(1, 3, 1);
      lit("d3_valid", int'(valid), int'(m_pend), 1);
      lit("d3_code",  int'(code),  m_code, 3);
      hold(1, 3, 1);
      lit("d3_ack", int'(valid), int'(m_pend), 0);
      hold(4, 3, 1);
      lit("d3_norecommit", int'(valid), int'(m_pend), 0);
      lit("d3_held_busy",  int'(busy),  int'(m_busy), 1);
      step(1, 0, 0, 1);
      step(1, 0, 0, 1);
      lit("d3_idle", int'(busy), int'(m_busy), 0);

      // 7 errors, code keeps 3
      hold(5, 7, 1);
      lit("d7_err",   int'(err),   int'(m_err), 1);
      lit("d7_valid", int'(valid), int'(m_pend), 0);
      lit("d7_code",  int'(code),  m_code, 3);
      hold(1, 7, 1);
      lit("d7_pulse", int'(err), int'(m_err), 0);
      step(1, 0, 0, 0);

      // MAX_CODE accepted, MAX_CODE+1 errors
      hold(5, 4, 0);
      lit("d4_valid", int'(valid), int'(m_pend), 1);
      lit("d4_code",  int'(code),  m_code, 4);
      step(1, 0, 0, 1);
      step(1, 0, 0, 0);
      hold(5, 5, 1);
      lit("d5_err",  int'(err),  int'(m_err), 1);
      lit("d5_code", int'(code), m_code, 4);
      step(1, 0, 0, 0);

      // bounce 2,2,1,1,1,1 commits 1; then ready low 5 cycles
      hold(2, 2, 0);
      hold(4, 1, 0);
      lit("bnc_latency", int'(valid), int'(m_pend), 0);
      hold(1, 1, 0);
      lit("bnc_valid", int'(valid), int'(m_pend), 1);
      lit("bnc_code",  int'(code),  m_code, 1);
      for (int i = 0; i < 5; i++) step(1, 1, 6, 0);
      lit("stall_valid", int'(valid), int'(m_pend), 1);
      lit("stall_code",  int'(code),  m_code, 1);
      step(1, 1, 6, 1);
      lit("stall_ack", int'(valid), int'(m_pend), 0);
      step(1, 0, 0, 0);

      // short press: nothing committed, busy falls back
      hold(3, 6, 1);
      step(1, 0, 0, 1);
      lit("short_busy",  int'(busy),  int'(m_busy), 0);
      lit("short_valid", int'(valid), int'(m_pend), 0);

      // reset while OUTPUT, then fresh digit 0 with normal latency
      hold(5, 2, 0);
      lit("pre_rst_valid", int'(valid), int'(m_pend), 1);
      step(0, 1, 2, 0);
      lit("mid_rst_valid", int'(valid), int'(m_pend), 0);
      lit("mid_rst_code",  int'(code),  m_code, 0);
      lit("mid_rst_busy",  int'(busy),  int'(m_busy), 0);
      step(1, 0, 0, 0);
      hold(4, 0, 0);
      lit("d0_latency", int'(valid), int'(m_pend), 0);
      hold(1, 0, 0);
      lit("d0_valid", int'(valid), int'(m_pend), 1);
      lit("d0_code",  int'(code),  m_code, 0);
      step(1, 0, 0, 1);
      step(1, 0, 0, 0);
      lit("end_busy", int'(busy), int'(m_busy), 0);

      checking = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bcd_to_state_encoder.md
BCD_TO_STATE_ENCODER -- requirements
Module: bcd_to_state_encoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: number of consecutive matching valid samples required to commit a digit; legal range 2..15.
REQ-002 Parameter MAX_CODE, default 4: highest BCD value accepted as a state code.
REQ-003 i_clk  input  1  single system clock; all logic on rising edge.
REQ-004 i_reset_n  input  1  synchronous, active-low reset.
REQ-005 i_bcd  input  4  candidate BCD digit (0..15 possible on the wire).
REQ-006 i_bcd_valid  input  1  i_bcd is meaningful this cycle (switch/key held).
REQ-007 i_ready  input  1  downstream FSM accepts o_code.
REQ-008 o_code  output  3  committed state code (BCD value truncated to 3 bits).
REQ-009 o_valid  output  1  o_code is new and awaiting acceptance.
REQ-010 o_err  output  1  one-cycle pulse: stable digit exceeded MAX_CODE.
REQ-011 o_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, FILTER, CHECK, OUTPUT and WAIT_RELEASE; all outputs registered.
REQ-013 IDLE: on an edge with i_bcd_valid=1, latch i_bcd into candidate, set count=1, go FILTER; otherwise stay.
REQ-014 FILTER, i_bcd_valid=1 and i_bcd==candidate: count+1; on reaching STABLE_CYCLES, go CHECK.
REQ-015 FILTER, i_bcd_valid=1 and i_bcd!=candidate: reload candidate, count=1, stay in FILTER (bounce restart).
REQ-016 FILTER, i_bcd_valid=0: count=0, go IDLE, no output.
REQ-017 CHECK lasts exactly one cycle: if candidate<=MAX_CODE, load o_code=candidate[2:0], set o_valid=1, go OUTPUT; else pulse o_err for one cycle, leave o_code unchanged, go WAIT_RELEASE.
REQ-018 Latency: first sampling edge E0; o_valid (or o_err) SHALL be high in the cycle after edge E0+STABLE_CYCLES.
REQ-019 OUTPUT: o_valid and o_code SHALL hold stable until an edge where o_valid=1 and i_ready=1; at that edge o_valid goes 0, state goes WAIT_RELEASE.
REQ-020 i_ready outside OUTPUT SHALL be ignored; i_bcd/i_bcd_valid changes during OUTPUT SHALL be ignored.
REQ-021 WAIT_RELEASE: stay until an edge with i_bcd_valid=0, then IDLE; a held digit SHALL never commit twice.
REQ-022 o_code SHALL retain the last committed value after o_valid drops and across error events.
REQ-023 Boundary: value MAX_CODE is accepted, MAX_CODE+1 errors; 0 is a legal code.
REQ-024 Count register SHALL be wide enough for 15 and SHALL never wrap.

Reset
REQ-025 While i_reset_n=0 at an edge: state=IDLE, candidate=0, count=0, o_code=0, o_valid=0, o_err=0, o_busy=0.
REQ-026 Reset SHALL take priority over every transition, including mid-FILTER and mid-OUTPUT; no pending code survives it.

Verification (STABLE_CYCLES=4, MAX_CODE=4)
REQ-027 i_bcd=3 valid for 6 cycles, i_ready=1 -> o_valid=1, o_code=3 for exactly one cycle after E4; no recommit while valid stays high.
REQ-028 i_bcd=7 held stable -> o_err high one cycle after E4, o_valid stays 0, o_code keeps prior value; i_bcd=4 -> accepted, i_bcd=5 -> o_err.
REQ-029 Bounce sequence 2,2,1,1,1,1 (valid high) -> commit o_code=1 after the fourth consecutive 1; 2 never appears.
REQ-030 Valid high for 3 samples then low -> no o_valid, no o_err, o_busy returns 0.
REQ-031 i_ready held low 5 cycles in OUTPUT -> o_valid and o_code stable throughout; handshake completes on first i_ready=1 edge.
REQ-032 i_reset_n=0 for one edge while in OUTPUT -> next cycle all outputs 0, state IDLE; fresh digit then commits with normal latency.
